rgb_to_yuv: RTL and testbench
=============================

// Module: rgb_to_yuv
// PURPOSE
//  Converts a stream of RGB888 pixel pairs into the 4:2:2 YUV byte stream U,Y1,V,Y2.
//  This is the byte format consumed by YUV_TO_RGB on its yuv_in port.
//  It is the op_mode=1 path of CTE: it drives yuv_out and the busy/out_valid mux.
//  Fixed-point conversion uses /256 coefficients, round-to-nearest, and saturation.
// PARAMETERS
//  CHROMA_AVG  1  1: U/V computed from the pixel-pair average; 0: U/V from pixel 0 only
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  in_en      in   1   rgb_in valid this cycle
//  rgb_in     in   24  pixel {R[23:16],G[15:8],B[7:0]}, unsigned
//  busy       out  1   1 = rgb_in not accepted this cycle
//  out_valid  out  1   yuv_out holds a valid byte this cycle
//  yuv_out    out  8   Y unsigned; U/V two's complement
// BEHAVIOUR
//  - One clock (clk). Reset is synchronous and active-high (reset).
//  - Reset values: state=WAIT0; pixel regs=0; busy=0; out_valid=0; yuv_out=8'h00.
//  - Reset mid-operation aborts the pair; the partial output sequence is not resumed.
//  - Accept rule: pixel accepted on a posedge where in_en=1 && busy=0.
//  - in_en=1 while busy=1: pixel ignored; upstream must hold it.
//  - in_en=0 never clears state; a held P0 is kept indefinitely.
//  - State machine (next state on posedge):
//      WAIT0: accept -> store P0, go WAIT1;                 else stay
//      WAIT1: accept -> store P1, go OUT_U;                 else stay
//      OUT_U -> OUT_Y1 -> OUT_V -> OUT_Y2 (unconditional)
//      OUT_Y2: accept -> store P0 (overwrite), go WAIT1;    else go WAIT0
//  - Combinational decodes of registered state only (no path from inputs):
//      busy      = state in {OUT_U, OUT_Y1, OUT_V}
//      out_valid = state in {OUT_U, OUT_Y1, OUT_V, OUT_Y2}
//  - OUT_Y2 overlap: Y2 uses only P1, so overwriting P0 in OUT_Y2 is safe.
//  - Latency: U appears the cycle after P1 is accepted; Y1, V, Y2 follow on consecutive cycles.
//  - Sustained throughput: one pair per 5 cycles.
//  - yuv_out = 8'h00 whenever out_valid=0.
//  - Luma (18-bit unsigned accumulator):
//      Yn = (77*Rn + 150*Gn + 29*Bn + 128) >> 8
//      saturate at 255; Y1 from P0, Y2 from P1
//  - Chroma (19-bit signed accumulator), CHROMA_AVG=1, with S = P0+P1 per channel (9-bit):
//      U = (-43*SR - 85*SG + 128*SB + 256) >>> 9
//      V = (128*SR - 107*SG - 21*SB + 256) >>> 9
//  - Chroma, CHROMA_AVG=0: same coefficients on P0, with +128 and >>>8.
//  - >>> is an arithmetic (floor) shift.
//  - U/V saturate to [-128, 127] before truncation to 8 bits.
// TESTING
//  T1 P0=P1=24'hFFFFFF -> U,Y1,V,Y2 = 00,FF,00,FF.
//  T2 P0=P1=24'h0000FF -> 7F(U saturated),1D,EB,1D.
//  T3 P0=24'hFF0000, P1=24'h000000, CHROMA_AVG=1 -> EB,4D,40,00.
//  T4 in_en held high, 4 pairs streamed:
//      busy pattern per period 0,0,1,1,1; out_valid high on 4 of every 5 cycles
//      P0' accepted in OUT_Y2; all bytes correct; no pixel dropped.
//  T5 reset pulsed for 1 cycle during OUT_V ->
//      next cycle out_valid=0, busy=0, yuv_out=00
//      next pair (T1 data) yields 00,FF,00,FF.
//  T6 P0 accepted, then in_en=0 for 3 cycles, then P1 (T3 data) ->
//      identical bytes to T3; out_valid stays 0 during the gap.

Source files
------------

// File: rtl/rgb_to_yuv.sv
// rgb_to_yuv
// Converts a stream of RGB888 pixel pairs into the 4:2:2 byte stream
// U, Y1, V, Y2, the byte order expected on the yuv_in port of the
// matching YUV-to-RGB block.
//
// Parameters
//   CHROMA_AVG  1: U/V from the pixel-pair average; 0: U/V from pixel 0 only
//
// Ports
//   clk        in   1   clock, all state changes on posedge
//   reset      in   1   synchronous, active-high
//   in_en      in   1   rgb_in valid this cycle
//   rgb_in     in   24  {R[23:16], G[15:8], B[7:0]}, unsigned
//   busy       out  1   1 = rgb_in is not accepted this cycle
//   out_valid  out  1   yuv_out carries a valid byte this cycle
//   yuv_out    out  8   Y unsigned, U/V two's complement; 00 when not valid
//
// state  | meaning
// -------+-----------------------------------------------------
// WAIT0  | idle, waiting for pixel 0 of a pair
// WAIT1  | pixel 0 held, waiting for pixel 1
// OUT_U  | driving U, input stalled
// OUT_Y1 | driving Y of pixel 0, input stalled
// OUT_V  | driving V, input stalled
// OUT_Y2 | driving Y of pixel 1; may accept the next pixel 0
module rgb_to_yuv #(
    parameter int CHROMA_AVG = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [23:0] rgb_in,
    output logic        busy,
    output logic        out_valid,
    output logic [7:0]  yuv_out
);

    localparam logic [2:0] WAIT0  = 3'd0;
    localparam logic [2:0] WAIT1  = 3'd1;
    localparam logic [2:0] OUT_U  = 3'd2;
    localparam logic [2:0] OUT_Y1 = 3'd3;
    localparam logic [2:0] OUT_V  = 3'd4;
    localparam logic [2:0] OUT_Y2 = 3'd5;

    // Averaging two pixels doubles the sum, so one extra shift bit and a
    // doubled rounding constant give the same scale as the single-pixel path.
    localparam int               SHIFT = (CHROMA_AVG != 0) ? 9 : 8;
    localparam logic signed [18:0] RND = (CHROMA_AVG != 0) ? 19'sd256 : 19'sd128;

    logic [2:0]  state;
    logic [23:0] p0;
    logic [23:0] p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT0;
            p0    <= 24'd0;
            p1    <= 24'd0;
        end else begin
            case (state)
                WAIT0: begin
                    if (in_en) begin
                        p0    <= rgb_in;
                        state <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (in_en) begin
                        p1    <= rgb_in;
                        state <= OUT_U;
                    end
                end
                OUT_U:  state <= OUT_Y1;
                OUT_Y1: state <= OUT_V;
                OUT_V:  state <= OUT_Y2;
                OUT_Y2: begin
                    // Y2 only reads p1, so p0 can be refilled while it is shown.
                    if (in_en) begin
                        p0    <= rgb_in;
                        state <= WAIT1;
                    end else begin
                        state <= WAIT0;
                    end
                end
                default: state <= WAIT0;
            endcase
        end
    end

    assign busy      = (state == OUT_U) || (state == OUT_Y1) || (state == OUT_V);
    assign out_valid = busy || (state == OUT_Y2);

    function automatic logic [7:0] luma(input logic [23:0] px);
        logic [17:0] acc;
        logic [17:0] sh;
        acc = 18'd77  * {10'd0, px[23:16]}
            + 18'd150 * {10'd0, px[15:8]}
            + 18'd29  * {10'd0, px[7:0]}
            + 18'd128;
        sh = acc >> 8;
        return (sh > 18'd255) ? 8'hFF : sh[7:0];
    endfunction

    function automatic logic [7:0] sat8(input logic signed [18:0] x);
        if (x > 19'sd127)
            return 8'h7F;
        else if (x < -19'sd128)
            return 8'h80;
        else
            return x[7:0];
    endfunction

    logic [8:0]         s_r, s_g, s_b;
    logic signed [18:0] c_r, c_g, c_b;
    logic signed [18:0] u_acc, v_acc;
    logic signed [18:0] u_sh, v_sh;
    logic [7:0]         u_byte, v_byte;

    always_comb begin
        if (CHROMA_AVG != 0) begin
            s_r = {1'b0, p0[23:16]} + {1'b0, p1[23:16]};
            s_g = {1'b0, p0[15:8]}  + {1'b0, p1[15:8]};
            s_b = {1'b0, p0[7:0]}   + {1'b0, p1[7:0]};
        end else begin
            s_r = {1'b0, p0[23:16]};
            s_g = {1'b0, p0[15:8]};
            s_b = {1'b0, p0[7:0]};
        end
    end

    assign c_r = $signed({10'd0, s_r});
    assign c_g = $signed({10'd0, s_g});
    assign c_b = $signed({10'd0, s_b});

    assign u_acc = 19'sd128 * c_b - 19'sd43 * c_r - 19'sd85 * c_g + RND;
    assign v_acc = 19'sd128 * c_r - 19'sd107 * c_g - 19'sd21 * c_b + RND;

    // Arithmetic shift floors negative values, matching the reference model.
    assign u_sh = u_acc >>> SHIFT;
    assign v_sh = v_acc >>> SHIFT;

    assign u_byte = sat8(u_sh);
    assign v_byte = sat8(v_sh);

    always_comb begin
        yuv_out = 8'h00;
        case (state)
            OUT_U:   yuv_out = u_byte;
            OUT_Y1:  yuv_out = luma(p0);
            OUT_V:   yuv_out = v_byte;
            OUT_Y2:  yuv_out = luma(p1);
            default: yuv_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_rgb_to_yuv.sv
module tb_rgb_to_yuv;

    logic        clk;
    logic        reset;
    logic        in_en;
    logic [23:0] rgb_in;
    logic        busy_a, out_valid_a;
    logic [7:0]  yuv_out_a;
    logic        busy_b, out_valid_b;
    logic [7:0]  yuv_out_b;

    int n_err = 0;
    int n_chk = 0;

    rgb_to_yuv #(.CHROMA_AVG(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .rgb_in    (rgb_in),
        .busy      (busy_a),
        .out_valid (out_valid_a),
        .yuv_out   (yuv_out_a)
    );

    rgb_to_yuv #(.CHROMA_AVG(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .rgb_in    (rgb_in),
        .busy      (busy_b),
        .out_valid (out_valid_b),
        .yuv_out   (yuv_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks both instances; yb is the expected byte of the pixel-0-chroma instance.
    task automatic chk_out(input string tag, input logic ov, input logic bz,
                           input logic [7:0] ya, input logic [7:0] yb);
        chk({tag, ".ov"},   {31'd0, out_valid_a}, {31'd0, ov});
        chk({tag, ".busy"}, {31'd0, busy_a},      {31'd0, bz});
        chk({tag, ".yuv"},  {24'd0, yuv_out_a},   {24'd0, ya});
        chk({tag, ".ovb"},  {31'd0, out_valid_b}, {31'd0, ov});
        chk({tag, ".busyb"},{31'd0, busy_b},      {31'd0, bz});
        chk({tag, ".yuvb"}, {24'd0, yuv_out_b},   {24'd0, yb});
    endtask

    // ea/eb = {U, Y1, V, Y2} for the averaging / pixel-0 instances.
    task automatic run_pair(input string tag, input logic [23:0] p0, input logic [23:0] p1,
                            input int gap, input logic [31:0] ea, input logic [31:0] eb);
        in_en  = 1'b1;
        rgb_in = p0;
        tick;
        chk_out({tag, ".w1"}, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int g = 0; g < gap; g++) begin
            in_en  = 1'b0;
            rgb_in = 24'hA5A5A5;
            tick;
            chk_out({tag, ".gap"}, 1'b0, 1'b0, 8'h00, 8'h00);
        end
        in_en  = 1'b1;
        rgb_in = p1;
        tick;
        in_en  = 1'b0;
        rgb_in = 24'h5A5A5A;
        chk_out({tag, ".u"},  1'b1, 1'b1, ea[31:24], eb[31:24]);
        tick;
        chk_out({tag, ".y1"}, 1'b1, 1'b1, ea[23:16], eb[23:16]);
        tick;
        chk_out({tag, ".v"},  1'b1, 1'b1, ea[15:8],  eb[15:8]);
        tick;
        chk_out({tag, ".y2"}, 1'b1, 1'b0, ea[7:0],   eb[7:0]);
        tick;
        chk_out({tag, ".idle"}, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    logic [23:0] s_p0 [4];
    logic [23:0] s_p1 [4];
    logic [31:0] s_ea [4];
    logic [31:0] s_eb [4];

    initial begin
        s_p0[0] = 24'hFFFFFF; s_p1[0] = 24'hFFFFFF; s_ea[0] = 32'h00FF00FF; s_eb[0] = 32'h00FF00FF;
        s_p0[1] = 24'h0000FF; s_p1[1] = 24'h0000FF; s_ea[1] = 32'h7F1DEB1D; s_eb[1] = 32'h7F1DEB1D;
        s_p0[2] = 24'hFF0000; s_p1[2] = 24'h000000; s_ea[2] = 32'hEB4D4000; s_eb[2] = 32'hD54D7F00;
        s_p0[3] = 24'h00FF00; s_p1[3] = 24'h00FF00; s_ea[3] = 32'hAB959595; s_eb[3] = 32'hAB959595;

        reset  = 1'b1;
        in_en  = 1'b0;
        rgb_in = 24'h000000;
        tick;
        tick;
        reset = 1'b0;
        chk_out("rst", 1'b0, 1'b0, 8'h00, 8'h00);

        run_pair("t1", 24'hFFFFFF, 24'hFFFFFF, 0, 32'h00FF00FF, 32'h00FF00FF);
        run_pair("t2", 24'h0000FF, 24'h0000FF, 0, 32'h7F1DEB1D, 32'h7F1DEB1D);
        run_pair("t3", 24'hFF0000, 24'h000000, 0, 32'hEB4D4000, 32'hD54D7F00);
        run_pair("grn", 24'h00FF00, 24'h00FF00, 0, 32'hAB959595, 32'hAB959595);

        // Streaming with in_en held high; junk presented during busy must be ignored.
        in_en  = 1'b1;
        rgb_in = s_p0[0];
        for (int k = 0; k < 4; k++) begin
            rgb_in = s_p0[k];
            tick;
            chk_out("t4.w1", 1'b0, 1'b0, 8'h00, 8'h00);
            rgb_in = s_p1[k];
            tick;
            rgb_in = 24'h123456;
            chk_out("t4.u",  1'b1, 1'b1, s_ea[k][31:24], s_eb[k][31:24]);
            tick;
            chk_out("t4.y1", 1'b1, 1'b1, s_ea[k][23:16], s_eb[k][23:16]);
            tick;
            chk_out("t4.v",  1'b1, 1'b1, s_ea[k][15:8],  s_eb[k][15:8]);
            if (k < 3) rgb_in = s_p0[k + 1];
            else       in_en  = 1'b0;
            tick;
            chk_out("t4.y2", 1'b1, 1'b0, s_ea[k][7:0],   s_eb[k][7:0]);
        end
        tick;
        chk_out("t4.end", 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset pulsed while V is on the output.
        in_en  = 1'b1;
        rgb_in = 24'hFF0000;
        tick;
        rgb_in = 24'h000000;
        tick;
        in_en = 1'b0;
        chk_out("t5.u", 1'b1, 1'b1, 8'hEB, 8'hD5);
        tick;
        tick;
        chk_out("t5.v", 1'b1, 1'b1, 8'h40, 8'h7F);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk_out("t5.rst", 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        chk_out("t5.hold", 1'b0, 1'b0, 8'h00, 8'h00);
        run_pair("t5.nxt", 24'hFFFFFF, 24'hFFFFFF, 0, 32'h00FF00FF, 32'h00FF00FF);

        // P0 held across an input gap.
        run_pair("t6", 24'hFF0000, 24'h000000, 3, 32'hEB4D4000, 32'hD54D7F00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
